// File: rtl/instruction_fetch_queue_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_queue_if
//   Groups the instruction-memory request/response bus and the datapath
//   consumer/redirect bus of the instruction fetch queue.
//
//   master : fetch queue side (drives requests and the head instruction)
//   slave  : environment side (memory + datapath)
//
//   IMemReq     fetch request, address valid while high
//   IMemAddr    word-aligned fetch address
//   IMemAck     memory accepts the request (meaningful only while IMemReq=1)
//   IMemValid   response word valid
//   IMemData    returned instruction word
//   InstrValid  head entry available
//   Instruction head instruction word
//   InstrPC     PC of the head instruction
//   InstrTake   consumer pops the head this cycle
//   Redirect    flush and restart fetch
//   RedirectPC  new fetch address, sampled with Redirect
// -----------------------------------------------------------------------------
interface instruction_fetch_queue_if;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemAck;
   logic        IMemValid;
   logic [31:0] IMemData;
   logic        InstrValid;
   logic [31:0] Instruction;
   logic [31:0] InstrPC;
   logic        InstrTake;
   logic        Redirect;
   logic [31:0] RedirectPC;

   modport master (
      output IMemReq, IMemAddr, InstrValid, Instruction, InstrPC,
      input  IMemAck, IMemValid, IMemData, InstrTake, Redirect, RedirectPC
   );

   modport slave (
      input  IMemReq, IMemAddr, InstrValid, Instruction, InstrPC,
      output IMemAck, IMemValid, IMemData, InstrTake, Redirect, RedirectPC
   );
endinterface

// File: rtl/instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// instruction_fetch_queue
//   Prefetch buffer between instruction memory and decode. Issues sequential
//   word fetches with at most one request outstanding, buffers returned words
//   with their PCs in a DEPTH-entry FIFO, and hands them to the datapath over a
//   valid/take handshake. Redirect flushes the buffer and restarts fetch.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   Clk    sole clock, rising edge
//   Reset  asynchronous, active-high reset
//   bus    instruction_fetch_queue_if.master (memory + datapath handshakes)
//
// Build option
//   FETCHQ_BYPASS_EN  when defined, a response arriving while the FIFO is empty
//                     is presented on the outputs in the same cycle and, if
//                     taken, is never written to the FIFO. Undefined: fixed
//                     one-cycle response-to-InstrValid latency, no
//                     combinational path from the memory response to outputs.
// -----------------------------------------------------------------------------
module instruction_fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                      Clk,
   input  logic                      Reset,
   instruction_fetch_queue_if.master bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DROP  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next_state;

   logic [31:0]      r_fetch_pc;
   logic [31:0]      r_req_pc;
   logic [31:0]      r_fifo_pc    [DEPTH];
   logic [31:0]      r_fifo_instr [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;

   logic             w_empty;
   logic             w_full;
   logic             w_req;
   logic             w_accept;
   logic             w_resp;
   logic             w_bypass;
   logic             w_bypass_take;
   logic             w_push;
   logic             w_pop;

   // --------------------------------------------------------------------------
   // Handshake qualification
   // --------------------------------------------------------------------------
   always_comb begin
      w_empty  = (r_count == '0);
      w_full   = (r_count == FULL_COUNT);
      // Space is checked only at issue: with one request in flight the count
      // cannot grow before that response returns.
      w_req    = (r_state == ST_FETCH) && !w_full && !bus.Redirect && !Reset;
      w_accept = w_req && bus.IMemAck;
      w_resp   = (r_state == ST_WAIT) && bus.IMemValid && !bus.Redirect;
`ifdef FETCHQ_BYPASS_EN
      w_bypass = w_resp && w_empty;
`else
      w_bypass = 1'b0;
`endif
      // A bypassed word that is taken immediately never enters the FIFO.
      w_bypass_take = w_bypass && bus.InstrTake;
      w_push        = w_resp && !w_bypass_take;
      w_pop         = !w_empty && bus.InstrTake && !bus.Redirect;
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   always_comb begin
      bus.IMemReq     = w_req;
      bus.IMemAddr    = r_fetch_pc;
      bus.InstrValid  = !w_empty || w_bypass;
      bus.Instruction = r_fifo_instr[r_rd_ptr];
      bus.InstrPC     = r_fifo_pc[r_rd_ptr];
      if (w_bypass) begin
         bus.Instruction = bus.IMemData;
         bus.InstrPC     = r_req_pc;
      end
   end

   // --------------------------------------------------------------------------
   // Fetch FSM
   // --------------------------------------------------------------------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ST_FETCH: begin
            // w_accept is already gated by Redirect, so a redirect holds FETCH.
            if (w_accept) begin
               w_next_state = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.IMemValid) begin
               w_next_state = ST_FETCH;
            end else if (bus.Redirect) begin
               // The in-flight response belongs to the old stream; swallow it.
               w_next_state = ST_DROP;
            end
         end
         ST_DROP: begin
            if (bus.IMemValid) begin
               w_next_state = ST_FETCH;
            end
         end
         default: w_next_state = ST_FETCH;
      endcase
   end

   // --------------------------------------------------------------------------
   // Fetch address tracking
   // --------------------------------------------------------------------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= '0;
      end else if (bus.Redirect) begin
         r_fetch_pc <= bus.RedirectPC;
      end else if (w_accept) begin
         r_req_pc   <= r_fetch_pc;
         r_fetch_pc <= r_fetch_pc + 32'd4;
      end
   end

   // --------------------------------------------------------------------------
   // FIFO storage, pointers and occupancy
   // --------------------------------------------------------------------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_fifo_pc[i]    <= '0;
            r_fifo_instr[i] <= '0;
         end
      end else if (w_push) begin
         r_fifo_pc[r_wr_ptr]    <= r_req_pc;
         r_fifo_instr[r_wr_ptr] <= bus.IMemData;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (bus.Redirect) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_queue
//   Randomized bench: a variable-latency memory, a random consumer and random
//   redirects drive the queue; a queue-based reference model predicts every
//   output each cycle.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_queue;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCHQ_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   localparam int NUM_SEG    = 8;
   localparam int SEG_CYCLES = 250;
   localparam int TAKE_PCT  [NUM_SEG] = '{90,   0, 100, 50, 25, 100, 70,   5};
   localparam int REDIR_PCT [NUM_SEG] = '{ 0,   0,   4,  6,  3,  10,  2,   1};
   localparam int ACK_PCT   [NUM_SEG] = '{100, 80, 100, 60, 75,  50, 90, 100};

   logic Clk   = 1'b0;
   logic Reset = 1'b1;

   instruction_fetch_queue_if bus ();

   instruction_fetch_queue #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Memory contents: any address maps to a distinct word; address 0 holds
   // 0x20080005.
   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h2008_0005;
   endfunction

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_fetch_pc;
   logic [31:0] m_req_pc;
   int          m_pend;      // 0: nothing in flight, 1: keep response, 2: discard response

   // Memory model
   bit          mem_busy;
   int          mem_cnt;
   logic [31:0] mem_addr;

   function automatic bit model_req(input bit r);
      return (m_pend == 0) && (q.size() < int'(DEPTH)) && !r;
   endfunction

   function automatic bit model_byp(input bit r, input bit v);
      return BYPASS && (m_pend == 1) && v && !r && (q.size() == 0);
   endfunction

   task automatic model_step(input bit r, input logic [31:0] rpc, input bit v,
                             input bit take, input bit ack);
      bit req;
      bit byp;
      req = model_req(r);
      byp = model_byp(r, v);
      if (r) begin
         q.delete();
         m_fetch_pc = rpc;
         if (m_pend != 0) m_pend = v ? 0 : 2;
      end else begin
         if (take && q.size() > 0) void'(q.pop_front());
         if (m_pend == 1 && v) begin
            if (!(byp && take)) q.push_back('{pc: m_req_pc, instr: memfn(m_req_pc)});
            m_pend = 0;
         end else if (m_pend == 2 && v) begin
            m_pend = 0;
         end
         if (req && ack) begin
            m_pend     = 1;
            m_req_pc   = m_fetch_pc;
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
      end
   endtask

   task automatic check_outputs(input bit r, input bit v);
      bit          exp_valid;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc;
      bit          byp;
      byp       = model_byp(r, v);
      exp_valid = (q.size() != 0) || byp;
      exp_instr = (q.size() != 0) ? q[0].instr : memfn(m_req_pc);
      exp_pc    = (q.size() != 0) ? q[0].pc    : m_req_pc;
      check("IMemReq",    32'(bus.IMemReq),    32'(model_req(r)));
      check("IMemAddr",   bus.IMemAddr,        m_fetch_pc);
      check("InstrValid", 32'(bus.InstrValid), 32'(exp_valid));
      if (exp_valid) begin
         check("Instruction", bus.Instruction, exp_instr);
         check("InstrPC",     bus.InstrPC,     exp_pc);
      end
   endtask

   task automatic drive_idle();
      bus.IMemAck    = 1'b0;
      bus.IMemValid  = 1'b0;
      bus.IMemData   = '0;
      bus.InstrTake  = 1'b0;
      bus.Redirect   = 1'b0;
      bus.RedirectPC = '0;
   endtask

   task automatic apply_reset();
      @(negedge Clk);
      Reset = 1'b1;
      drive_idle();
      #1;
      check("rst_IMemReq",     32'(bus.IMemReq),    32'd0);
      check("rst_IMemAddr",    bus.IMemAddr,        RESET_PC);
      check("rst_InstrValid",  32'(bus.InstrValid), 32'd0);
      check("rst_Instruction", bus.Instruction,     32'd0);
      check("rst_InstrPC",     bus.InstrPC,         32'd0);
      q.delete();
      m_fetch_pc = RESET_PC;
      m_req_pc   = '0;
      m_pend     = 0;
      mem_busy   = 1'b0;
      mem_cnt    = 0;
      @(posedge Clk);
      @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      #1;
      check("post_rst_IMemReq", 32'(bus.IMemReq), 32'd1);
   endtask

   task automatic run_cycle(input int take_pct, input int redir_pct, input int ack_pct);
      bit          resp;
      bit          r;
      bit          take;
      bit          ack;
      bit          accepted;
      logic [31:0] rpc;
      logic [31:0] acc_addr;
      int          lat;
      @(negedge Clk);
      resp = mem_busy && (mem_cnt == 0);
      r    = int'($urandom_range(99)) < redir_pct;
      take = int'($urandom_range(99)) < take_pct;
      if ($urandom_range(2) == 0)
         rpc = 32'hFFFF_FFF0 | (32'($urandom_range(3)) << 2);
      else
         rpc = $urandom & 32'hFFFF_FFFC;
      bus.IMemValid  = resp;
      bus.IMemData   = resp ? memfn(mem_addr) : $urandom;
      bus.Redirect   = r;
      bus.RedirectPC = r ? rpc : $urandom;
      bus.InstrTake  = take;
      bus.IMemAck    = 1'b0;
      #1;
      check_outputs(r, resp);
      ack         = int'($urandom_range(99)) < ack_pct;
      bus.IMemAck = ack;
      #1;
      accepted = bus.IMemReq && ack;
      acc_addr = bus.IMemAddr;
      lat      = int'($urandom_range(3, 1));
      @(posedge Clk);
      model_step(r, rpc, resp, take, ack);
      if (resp) mem_busy = 1'b0;
      else if (mem_busy) mem_cnt--;
      if (accepted) begin
         mem_busy = 1'b1;
         mem_addr = acc_addr;
         mem_cnt  = lat - 1;
      end
   endtask

   initial begin
      drive_idle();
      apply_reset();
      for (int s = 0; s < NUM_SEG; s++) begin
         for (int c = 0; c < SEG_CYCLES; c++) begin
            run_cycle(TAKE_PCT[s], REDIR_PCT[s], ACK_PCT[s]);
         end
         if (s == 3) apply_reset();
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
